// File: rtl/ps2_pkg.sv
//------------------------------------------------------------------------------
// Module  : ps2_pkg
// Brief   : PS/2 set-2 scan-code constants, decoder FSM states, ASCII mapping
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ps2_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POP    = 2'd1,
    ST_SETTLE = 2'd2,
    ST_EMIT   = 2'd3
  } state_t;

  function automatic logic [7:0] scan2ascii(input logic [7:0] code, input logic shift);
    logic [7:0] ch;
    logic       letter;
    ch     = 8'h00;
    letter = 1'b1;
    case (code)
      8'h1C: ch = 8'h61;  8'h32: ch = 8'h62;  8'h21: ch = 8'h63;  8'h23: ch = 8'h64;
      8'h24: ch = 8'h65;  8'h2B: ch = 8'h66;  8'h34: ch = 8'h67;  8'h33: ch = 8'h68;
      8'h43: ch = 8'h69;  8'h3B: ch = 8'h6A;  8'h42: ch = 8'h6B;  8'h4B: ch = 8'h6C;
      8'h3A: ch = 8'h6D;  8'h31: ch = 8'h6E;  8'h44: ch = 8'h6F;  8'h4D: ch = 8'h70;
      8'h15: ch = 8'h71;  8'h2D: ch = 8'h72;  8'h1B: ch = 8'h73;  8'h2C: ch = 8'h74;
      8'h3C: ch = 8'h75;  8'h2A: ch = 8'h76;  8'h1D: ch = 8'h77;  8'h22: ch = 8'h78;
      8'h35: ch = 8'h79;  8'h1A: ch = 8'h7A;
      default: letter = 1'b0;
    endcase
    if (!letter) begin
      case (code)
        8'h45: ch = 8'h30;  8'h16: ch = 8'h31;  8'h1E: ch = 8'h32;  8'h26: ch = 8'h33;
        8'h25: ch = 8'h34;  8'h2E: ch = 8'h35;  8'h36: ch = 8'h36;  8'h3D: ch = 8'h37;
        8'h3E: ch = 8'h38;  8'h46: ch = 8'h39;
        8'h29: ch = 8'h20;  8'h5A: ch = 8'h0D;  8'h66: ch = 8'h08;
        default: ch = 8'h00;
      endcase
    end
    return (letter && shift) ? (ch - 8'h20) : ch;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_ascii_lut.sv
//------------------------------------------------------------------------------
// Module  : ps2_ascii_lut
// Brief   : Combinational {shift, scan code} -> ASCII ROM
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ps2_ascii_lut
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii
);

  logic [7:0] w_rom [512];

  for (genvar gi = 0; gi < 512; gi++) begin : g_rom
    localparam logic [8:0] c_idx = 9'(gi);
    assign w_rom[gi] = scan2ascii(c_idx[7:0], c_idx[8]);
  end

  assign ascii = w_rom[{shift, code}];

endmodule

`default_nettype wire

// File: rtl/ps2_scan_decoder.sv
//------------------------------------------------------------------------------
// Module  : ps2_scan_decoder
// Brief   : Pops PS/2 FIFO bytes, folds prefixes, emits key events + ASCII
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int E1_SKIP = 7,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_ready,
  input  logic             kbd_overflow,
  output logic             kbd_nextdata_n,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic             ev_repeat,
  output logic [7:0]       ev_ascii,
  output logic             shift_held,
  output logic [CNT_W-1:0] press_count,
  output logic             err_overflow
);

  localparam int c_SKIP_W = (E1_SKIP < 1) ? 1 : $clog2(E1_SKIP + 1);

  state_t             r_state, w_next;
  logic               r_nextdata_n, r_ev_valid;
  logic               w_pop_n, w_valid;
  logic [7:0]         r_byte;
  logic               r_ext_f, r_brk_f;
  logic [c_SKIP_W-1:0] r_skip;
  logic [8:0]         r_held;
  logic               r_held_vld;
  logic               r_lsh, r_rsh, r_shift_held;
  logic [7:0]         r_ev_code, r_ev_ascii;
  logic               r_ev_ext, r_ev_break, r_ev_repeat;
  logic [CNT_W-1:0]   r_press_count;
  logic               r_err;

  logic               w_skip_busy, w_is_event, w_repeat;
  logic [8:0]         w_key;
  logic               w_lsh_nxt, w_rsh_nxt;
  logic [7:0]         w_lut_ascii;

  ps2_ascii_lut u_lut (
    .code  (r_byte),
    .shift (r_shift_held),
    .ascii (w_lut_ascii)
  );

  always_comb begin
    w_skip_busy = (r_skip != '0);
    w_is_event  = !w_skip_busy && (r_byte != SC_PAUSE) && (r_byte != SC_EXT) && (r_byte != SC_BRK);
    w_key       = {r_ext_f, r_byte};
    w_repeat    = !r_brk_f && r_held_vld && (r_held == w_key);
    w_lsh_nxt   = (!r_ext_f && r_byte == SC_LSHIFT) ? !r_brk_f : r_lsh;
    w_rsh_nxt   = (!r_ext_f && r_byte == SC_RSHIFT) ? !r_brk_f : r_rsh;
  end

  // State register; strobe and valid are registered off the next state
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state      <= ST_IDLE;
      r_nextdata_n <= 1'b1;
      r_ev_valid   <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_nextdata_n <= w_pop_n;
      r_ev_valid   <= w_valid;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (kbd_ready) w_next = ST_POP;
      ST_POP:    w_next = ST_SETTLE;
      ST_SETTLE: w_next = w_is_event ? ST_EMIT : ST_IDLE;
      ST_EMIT:   if (ev_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_pop_n = (w_next != ST_POP);
    w_valid = (w_next == ST_EMIT);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_byte        <= 8'h00;
      r_ext_f       <= 1'b0;
      r_brk_f       <= 1'b0;
      r_skip        <= '0;
      r_held        <= 9'h000;
      r_held_vld    <= 1'b0;
      r_lsh         <= 1'b0;
      r_rsh         <= 1'b0;
      r_shift_held  <= 1'b0;
      r_ev_code     <= 8'h00;
      r_ev_ascii    <= 8'h00;
      r_ev_ext      <= 1'b0;
      r_ev_break    <= 1'b0;
      r_ev_repeat   <= 1'b0;
      r_press_count <= '0;
      r_err         <= 1'b0;
    end else begin
      if (kbd_overflow) r_err <= 1'b1;
      if (r_state == ST_IDLE && kbd_ready) r_byte <= kbd_data;
      if (r_state == ST_SETTLE) begin
        if (w_skip_busy) begin
          r_skip <= r_skip - c_SKIP_W'(1);
        end else if (r_byte == SC_PAUSE) begin
          r_skip <= c_SKIP_W'(E1_SKIP);
        end else if (r_byte == SC_EXT) begin
          r_ext_f <= 1'b1;
        end else if (r_byte == SC_BRK) begin
          r_brk_f <= 1'b1;
        end else begin
          r_ev_code    <= r_byte;
          r_ev_ext     <= r_ext_f;
          r_ev_break   <= r_brk_f;
          r_ev_repeat  <= w_repeat;
          r_ev_ascii   <= r_ext_f ? 8'h00 : w_lut_ascii;
          r_ext_f      <= 1'b0;
          r_brk_f      <= 1'b0;
          r_lsh        <= w_lsh_nxt;
          r_rsh        <= w_rsh_nxt;
          r_shift_held <= w_lsh_nxt | w_rsh_nxt;
          if (!r_brk_f) begin
            r_held     <= w_key;
            r_held_vld <= 1'b1;
            if (!w_repeat) r_press_count <= r_press_count + CNT_W'(1);
          end else if (r_held_vld && r_held == w_key) begin
            r_held_vld <= 1'b0;
          end
        end
      end
    end
  end

  assign kbd_nextdata_n = r_nextdata_n;
  assign ev_valid       = r_ev_valid;
  assign ev_code        = r_ev_code;
  assign ev_ext         = r_ev_ext;
  assign ev_break       = r_ev_break;
  assign ev_repeat      = r_ev_repeat;
  assign ev_ascii       = r_ev_ascii;
  assign shift_held     = r_shift_held;
  assign press_count    = r_press_count;
  assign err_overflow   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_scan_decoder.sv
//------------------------------------------------------------------------------
// Module  : tb_ps2_scan_decoder
// Brief   : FIFO model + scoreboard bench for ps2_scan_decoder
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ps2_scan_decoder;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] kbd_data = 8'h00;
  logic       kbd_ready = 1'b0;
  logic       kbd_overflow = 1'b0;
  logic       kbd_nextdata_n;
  logic       ev_valid;
  logic       ev_ready = 1'b1;
  logic [7:0] ev_code;
  logic       ev_ext, ev_break, ev_repeat;
  logic [7:0] ev_ascii;
  logic       shift_held;
  logic [7:0] press_count;
  logic       err_overflow;

  ps2_scan_decoder #(.E1_SKIP(7), .CNT_W(8)) dut (
    .clk(clk), .clr(clr), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
    .kbd_overflow(kbd_overflow), .kbd_nextdata_n(kbd_nextdata_n),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_break(ev_break), .ev_repeat(ev_repeat), .ev_ascii(ev_ascii),
    .shift_held(shift_held), .press_count(press_count), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
    logic [7:0] ascii;
    logic [7:0] cnt;
    logic       sh;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] fifo_q[$];
  int         checks = 0;
  int         errors = 0;
  int         pops = 0;
  logic       prev_low = 1'b0;
  logic       pop_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic ev_t mk(input logic [7:0] c, input logic x, input logic b, input logic r,
                             input logic [7:0] a, input logic [7:0] n, input logic s);
    ev_t e;
    e.code = c; e.ext = x; e.brk = b; e.rep = r; e.ascii = a; e.cnt = n; e.sh = s;
    return e;
  endfunction

  // FIFO model: strobe sampled mid-cycle, pop applied on the following edge
  always @(negedge clk) begin
    pop_req = !kbd_nextdata_n;
    if (!kbd_nextdata_n) begin
      pops++;
      chk("pop_width", 32'(prev_low), 32'd0);
    end
    prev_low = !kbd_nextdata_n;
  end

  always @(posedge clk) begin
    if (pop_req && fifo_q.size() > 0) void'(fifo_q.pop_front());
    kbd_ready <= (fifo_q.size() != 0);
    kbd_data  <= (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  end

  // Monitor: compare each accepted event against the scoreboard head
  always @(negedge clk) begin
    if (!clr && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: actual code %0h required no event", ev_code);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("ev_code",     32'(ev_code),     32'(e.code));
        chk("ev_ext",      32'(ev_ext),      32'(e.ext));
        chk("ev_break",    32'(ev_break),    32'(e.brk));
        chk("ev_repeat",   32'(ev_repeat),   32'(e.rep));
        chk("ev_ascii",    32'(ev_ascii),    32'(e.ascii));
        chk("press_count", 32'(press_count), 32'(e.cnt));
        chk("shift_held",  32'(shift_held),  32'(e.sh));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic do_reset();
    tick();
    clr = 1'b1;
    @(negedge clk);
    chk("rst_ev_valid",    32'(ev_valid),       32'd0);
    chk("rst_nextdata_n",  32'(kbd_nextdata_n), 32'd1);
    chk("rst_press_count", 32'(press_count),    32'd0);
    chk("rst_shift_held",  32'(shift_held),     32'd0);
    chk("rst_err",         32'(err_overflow),   32'd0);
    chk("rst_ev_code",     32'(ev_code),        32'd0);
    chk("rst_ev_break",    32'(ev_break),       32'd0);
    tick();
    clr = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: actual %0d pending events required 0", name, exp_q.size());
      exp_q.delete();
      fifo_q.delete();
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    int p0;
    int n;
    repeat (3) tick();

    // Make and break of 'a'
    do_reset();
    p0 = pops;
    exp_q.push_back(mk(8'h1C, 0, 0, 0, 8'h61, 8'd1, 0));
    exp_q.push_back(mk(8'h1C, 0, 1, 0, 8'h61, 8'd1, 0));
    push(8'h1C); push(8'hF0); push(8'h1C);
    drain("g1");
    chk("g1_pops", 32'(pops - p0), 32'd3);

    // Shifted letter, shift release
    do_reset();
    exp_q.push_back(mk(8'h12, 0, 0, 0, 8'h00, 8'd1, 1));
    exp_q.push_back(mk(8'h1C, 0, 0, 0, 8'h41, 8'd2, 1));
    exp_q.push_back(mk(8'h12, 0, 1, 0, 8'h00, 8'd2, 0));
    exp_q.push_back(mk(8'h1C, 0, 0, 1, 8'h61, 8'd2, 0));
    push(8'h12); push(8'h1C); push(8'hF0); push(8'h12); push(8'h1C);
    drain("g2");
    chk("g2_shift_after", 32'(shift_held), 32'd0);

    // Extended key make/break
    do_reset();
    exp_q.push_back(mk(8'h75, 1, 0, 0, 8'h00, 8'd1, 0));
    exp_q.push_back(mk(8'h75, 1, 1, 0, 8'h00, 8'd1, 0));
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    drain("g3");

    // Typematic repeat
    do_reset();
    exp_q.push_back(mk(8'h1C, 0, 0, 0, 8'h61, 8'd1, 0));
    exp_q.push_back(mk(8'h1C, 0, 0, 1, 8'h61, 8'd1, 0));
    exp_q.push_back(mk(8'h1C, 0, 0, 1, 8'h61, 8'd1, 0));
    push(8'h1C); push(8'h1C); push(8'h1C);
    drain("g4");
    chk("g4_count", 32'(press_count), 32'd1);

    // Backpressure with four bytes queued
    do_reset();
    ev_ready = 1'b0;
    exp_q.push_back(mk(8'h1B, 0, 0, 0, 8'h73, 8'd1, 0));
    exp_q.push_back(mk(8'h23, 0, 0, 0, 8'h64, 8'd2, 0));
    exp_q.push_back(mk(8'h2B, 0, 0, 0, 8'h66, 8'd3, 0));
    exp_q.push_back(mk(8'h34, 0, 0, 0, 8'h67, 8'd4, 0));
    push(8'h1B); push(8'h23); push(8'h2B); push(8'h34);
    n = 0;
    @(negedge clk);
    while (!ev_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", 32'(ev_valid), 32'd1);
    p0 = pops;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_valid",      32'(ev_valid),       32'd1);
      chk("bp_code",       32'(ev_code),        32'h1B);
      chk("bp_nextdata_n", 32'(kbd_nextdata_n), 32'd1);
    end
    chk("bp_no_pops",   32'(pops - p0),      32'd0);
    chk("bp_fifo_left", 32'(fifo_q.size()),  32'd3);
    tick();
    ev_ready = 1'b1;
    drain("g5");

    // Pause sequence swallowed, then a normal key
    do_reset();
    push(8'hE1); push(8'h14); push(8'h77); push(8'hE1);
    push(8'hF0); push(8'h14); push(8'hF0); push(8'h77);
    drain("g6a");
    chk("g6_count", 32'(press_count), 32'd0);
    exp_q.push_back(mk(8'h1C, 0, 0, 0, 8'h61, 8'd1, 0));
    push(8'h1C);
    drain("g6b");

    // Reset discards a pending break prefix
    do_reset();
    push(8'hF0);
    drain("g7a");
    do_reset();
    exp_q.push_back(mk(8'h1C, 0, 0, 0, 8'h61, 8'd1, 0));
    push(8'h1C);
    drain("g7b");

    // Sticky overflow
    do_reset();
    tick();
    kbd_overflow = 1'b1;
    tick();
    kbd_overflow = 1'b0;
    repeat (3) tick();
    chk("ovf_set", 32'(err_overflow), 32'd1);
    repeat (20) tick();
    chk("ovf_sticky", 32'(err_overflow), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
